// File: rtl/hazard_unit_pkg.sv
// Shared pipeline-control constants for the MIPS hazard logic: sentinel codes
// from the decoder and the forward-mux select encoding.
package cpu_defs;

  localparam logic [3:0] TUSE_NONE = 4'd15;
  localparam logic [3:0] TNEW_NONE = 4'd15;
  localparam int         TNEW_MAX  = 3;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/hz_stage_rec.sv
// Shadow record of one pipeline stage {a3, tnew, rs, rt}; tnew counts down as
// the instruction advances and a bubble loads an empty record.
module hz_stage_rec
  import cpu_defs::*;
#(
  parameter int REG_AW = 5,
  parameter int IN_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble_i,
  input  logic [REG_AW-1:0] a3_i,
  input  logic [IN_W-1:0]   tnew_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  output logic [REG_AW-1:0] a3_o,
  output logic [1:0]        tnew_o,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o
);

  logic [REG_AW-1:0] a3_q, a3_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [1:0]        tnew_q, tnew_d;
  logic [1:0]        tnewLoad;
  logic [IN_W-1:0]   tnewDec;

  assign tnewDec = (tnew_i == '0) ? '0 : tnew_i - IN_W'(1);

  // Wide decoder codes are clamped so the record fits in two bits.
  if (IN_W > 2) begin : gClamp
    assign tnewLoad = (tnewDec > IN_W'(TNEW_MAX)) ? 2'(TNEW_MAX) : tnewDec[1:0];
  end else begin : gDirect
    assign tnewLoad = tnewDec[1:0];
  end

  always_comb begin
    a3_d   = a3_i;
    tnew_d = tnewLoad;
    rs_d   = rs_i;
    rt_d   = rt_i;
    if (bubble_i) begin
      a3_d   = '0;
      tnew_d = 2'd0;
      rs_d   = '0;
      rt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a3_q   <= '0;
      tnew_q <= 2'd0;
      rs_q   <= '0;
      rt_q   <= '0;
    end else begin
      a3_q   <= a3_d;
      tnew_q <= tnew_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
    end
  end

  assign a3_o   = a3_q;
  assign tnew_o = tnew_q;
  assign rs_o   = rs_q;
  assign rt_o   = rt_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall and forwarding controller for the 5-stage MIPS pipeline, driven by the
// decoder's Tuse/Tnew codes and shadow records of the E, M and W stages.
module hazard_unit
  import cpu_defs::*;
#(
  parameter int REG_AW = 5,
  parameter int T_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic [T_W-1:0]    d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [1:0]        fwd_m_rt
);

  logic [REG_AW-1:0] eA3, mA3, wA3;
  logic [REG_AW-1:0] eRs, eRt, mRs, mRt, wRs, wRt;
  logic [1:0]        eTnew, mTnew, wTnew;
  logic              dKill;
  logic [REG_AW-1:0] dA3Eff;
  logic [T_W-1:0]    dTnewEff;
  logic              unusedWOps;

  function automatic logic regHit(input logic [REG_AW-1:0] src,
                                  input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic logic needsStall(input logic hit, input logic [1:0] tnew,
                                      input logic [T_W-1:0] tuse);
    return hit && (tuse != T_W'(TUSE_NONE)) && (T_W'(tnew) > tuse);
  endfunction

  // Nearest matching stage wins; it forwards only once its result is ready.
  function automatic logic [1:0] pickFwd(input logic hitE, input logic hitM,
                                         input logic hitW, input logic [1:0] tnE,
                                         input logic [1:0] tnM, input logic [1:0] tnW);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (hitE)      sel = (tnE == 2'd0) ? FWD_E : FWD_NONE;
    else if (hitM) sel = (tnM == 2'd0) ? FWD_M : FWD_NONE;
    else if (hitW) sel = (tnW == 2'd0) ? FWD_W : FWD_NONE;
    return sel;
  endfunction

  assign dKill    = (d_tnew == T_W'(TNEW_NONE));
  assign dA3Eff   = dKill ? '0 : d_a3;
  assign dTnewEff = dKill ? '0 : d_tnew;

  hz_stage_rec #(.REG_AW(REG_AW), .IN_W(T_W)) uRecE (
    .clk(clk), .reset(reset), .bubble_i(stall),
    .a3_i(dA3Eff), .tnew_i(dTnewEff), .rs_i(d_rs), .rt_i(d_rt),
    .a3_o(eA3), .tnew_o(eTnew), .rs_o(eRs), .rt_o(eRt)
  );

  hz_stage_rec #(.REG_AW(REG_AW), .IN_W(2)) uRecM (
    .clk(clk), .reset(reset), .bubble_i(1'b0),
    .a3_i(eA3), .tnew_i(eTnew), .rs_i(eRs), .rt_i(eRt),
    .a3_o(mA3), .tnew_o(mTnew), .rs_o(mRs), .rt_o(mRt)
  );

  hz_stage_rec #(.REG_AW(REG_AW), .IN_W(2)) uRecW (
    .clk(clk), .reset(reset), .bubble_i(1'b0),
    .a3_i(mA3), .tnew_i(mTnew), .rs_i(mRs), .rt_i(mRt),
    .a3_o(wA3), .tnew_o(wTnew), .rs_o(wRs), .rt_o(wRt)
  );

  // W's operand fields complete the record but nothing downstream reads them.
  assign unusedWOps = ^{wRs, wRt};

  assign stall = needsStall(regHit(d_rs, eA3), eTnew, d_tuse_rs)
               | needsStall(regHit(d_rs, mA3), mTnew, d_tuse_rs)
               | needsStall(regHit(d_rt, eA3), eTnew, d_tuse_rt)
               | needsStall(regHit(d_rt, mA3), mTnew, d_tuse_rt);

  assign fwd_d_rs = pickFwd(regHit(d_rs, eA3), regHit(d_rs, mA3), regHit(d_rs, wA3),
                            eTnew, mTnew, wTnew);
  assign fwd_d_rt = pickFwd(regHit(d_rt, eA3), regHit(d_rt, mA3), regHit(d_rt, wA3),
                            eTnew, mTnew, wTnew);
  assign fwd_e_rs = pickFwd(1'b0, regHit(eRs, mA3), regHit(eRs, wA3),
                            eTnew, mTnew, wTnew);
  assign fwd_e_rt = pickFwd(1'b0, regHit(eRt, mA3), regHit(eRt, wA3),
                            eTnew, mTnew, wTnew);
  assign fwd_m_rt = pickFwd(1'b0, 1'b0, regHit(mRt, wA3),
                            eTnew, mTnew, wTnew);

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the reference tracks each in-flight
// instruction by the absolute cycle its result becomes forwardable.
module tb_hazard_unit;
  import cpu_defs::*;

  localparam int REG_AW        = 5;
  localparam int T_W           = 4;
  localparam int RANDOM_CYCLES = 600;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] d_rs, d_rt, d_a3;
  logic [T_W-1:0]    d_tuse_rs, d_tuse_rt, d_tnew;
  logic              stall;
  logic [1:0]        fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(REG_AW), .T_W(T_W)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_a3(d_a3),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
    .stall(stall),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
  );

  typedef struct {
    logic [REG_AW-1:0] dst;
    int                readyAt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } slot_t;

  typedef struct {
    logic       stall;
    logic [1:0] dRs, dRt, eRs, eRt, mRt;
  } expect_t;

  slot_t   pipe [3];
  expect_t sbQueue [$];
  int      now = 0;
  int      vectors = 0;
  int      miscompares = 0;
  logic    lastStall = 1'b0;

  function automatic slot_t emptySlot();
    slot_t s;
    s.dst = '0; s.readyAt = 0; s.rs = '0; s.rt = '0;
    return s;
  endfunction

  // Cycles still to wait before slot i's result can be forwarded.
  function automatic int remaining(input int i);
    int r;
    r = pipe[i].readyAt - now;
    if (r < 0) r = 0;
    if (r > 3) r = 3;
    return r;
  endfunction

  function automatic logic stallFor(input logic [REG_AW-1:0] src, input logic [T_W-1:0] tuse);
    logic s;
    s = 1'b0;
    for (int i = 0; i < 2; i++)
      if (src != '0 && src == pipe[i].dst && tuse != TUSE_NONE && remaining(i) > int'(tuse))
        s = 1'b1;
    return s;
  endfunction

  function automatic logic [1:0] fwdFrom(input logic [REG_AW-1:0] src, input int first);
    logic [1:0] sel;
    logic       found;
    sel = 2'd0;
    found = 1'b0;
    for (int i = first; i < 3; i++)
      if (!found && src != '0 && pipe[i].dst == src) begin
        found = 1'b1;
        sel = (remaining(i) == 0) ? 2'(i + 1) : 2'd0;
      end
    return sel;
  endfunction

  function automatic expect_t modelExpect();
    expect_t e;
    e.stall = stallFor(d_rs, d_tuse_rs) | stallFor(d_rt, d_tuse_rt);
    e.dRs   = fwdFrom(d_rs, 0);
    e.dRt   = fwdFrom(d_rt, 0);
    e.eRs   = fwdFrom(pipe[0].rs, 1);
    e.eRt   = fwdFrom(pipe[0].rt, 1);
    e.mRt   = fwdFrom(pipe[1].rt, 2);
    return e;
  endfunction

  function automatic void advanceModel();
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = emptySlot();
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (lastStall) begin
        pipe[0] = emptySlot();
      end else begin
        pipe[0].rs = d_rs;
        pipe[0].rt = d_rt;
        if (d_tnew == TNEW_NONE) begin
          pipe[0].dst = '0;
          pipe[0].readyAt = 0;
        end else begin
          pipe[0].dst = d_a3;
          pipe[0].readyAt = now + int'(d_tnew);
        end
      end
    end
    now++;
  endfunction

  task automatic applyStimulus(input logic rst, input int rs, input int rt, input int a3,
                               input int tuRs, input int tuRt, input int tn);
    expect_t e;
    @(posedge clk);
    #1;
    advanceModel();
    reset     = rst;
    d_rs      = REG_AW'(rs);
    d_rt      = REG_AW'(rt);
    d_a3      = REG_AW'(a3);
    d_tuse_rs = T_W'(tuRs);
    d_tuse_rt = T_W'(tuRt);
    d_tnew    = T_W'(tn);
    e = modelExpect();
    sbQueue.push_back(e);
    lastStall = e.stall;
  endtask

  // Holds the instruction in D for as long as the pipeline is frozen.
  task automatic issueInstr(input int rs, input int rt, input int a3,
                            input int tuRs, input int tuRt, input int tn);
    int tries;
    tries = 0;
    applyStimulus(1'b0, rs, rt, a3, tuRs, tuRt, tn);
    while (lastStall && tries < 8) begin
      applyStimulus(1'b0, rs, rt, a3, tuRs, tuRt, tn);
      tries++;
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issueInstr(0, 0, 0, 15, 15, 15);
  endtask

  task automatic checkField(input string name, input logic [1:0] got, input logic [1:0] want);
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    vectors++;
    checkField("stall",    {1'b0, stall}, {1'b0, e.stall});
    checkField("fwd_d_rs", fwd_d_rs, e.dRs);
    checkField("fwd_d_rt", fwd_d_rt, e.dRt);
    checkField("fwd_e_rs", fwd_e_rs, e.eRs);
    checkField("fwd_e_rt", fwd_e_rt, e.eRt);
    checkField("fwd_m_rt", fwd_m_rt, e.mRt);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
    end
  end

  function automatic int randTuse();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 1;
      2:       return 2;
      default: return 15;
    endcase
  endfunction

  function automatic int randTnew();
    int v;
    v = int'($urandom_range(0, 4));
    return (v == 4) ? 15 : v;
  endfunction

  initial begin
    reset = 1'b1;
    d_rs = '0; d_rt = '0; d_a3 = '0;
    d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE; d_tnew = TNEW_NONE;
    $display("[TB] hazard_unit scoreboard run starting");

    applyStimulus(1'b1, 0, 0, 0, 15, 15, 15);
    applyStimulus(1'b1, 0, 0, 0, 15, 15, 15);
    nops(2);

    // add $1,$2,$3 ; beq $1,$0
    issueInstr(2, 3, 1, 1, 1, 2);
    issueInstr(1, 0, 0, 0, 0, 15);
    nops(3);
    // lw $4,0($0) ; add $5,$4,$4
    issueInstr(0, 4, 4, 1, 15, 3);
    issueInstr(4, 4, 5, 1, 1, 2);
    nops(3);
    // jal ; jr $31
    issueInstr(0, 0, 31, 15, 15, 0);
    issueInstr(31, 0, 0, 0, 15, 15);
    nops(3);
    // lw $6 ; sw $6,0($0)
    issueInstr(0, 6, 6, 1, 15, 3);
    issueInstr(0, 6, 0, 1, 2, 15);
    nops(3);
    // ori $0,$0,5 ; add $7,$0,$0
    issueInstr(0, 0, 0, 1, 15, 2);
    issueInstr(0, 0, 7, 1, 1, 2);
    nops(3);
    // lw $4 ; add stalled, reset asserted during the stall
    issueInstr(0, 4, 4, 1, 15, 3);
    applyStimulus(1'b1, 4, 4, 5, 1, 1, 2);
    issueInstr(4, 4, 5, 1, 1, 2);
    nops(3);

    for (int n = 0; n < RANDOM_CYCLES; n++) begin
      if (lastStall)
        applyStimulus(1'b0, int'(d_rs), int'(d_rt), int'(d_a3),
                      int'(d_tuse_rs), int'(d_tuse_rt), int'(d_tnew));
      else
        applyStimulus($urandom_range(0, 49) == 0,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), randTuse(), randTuse(), randTnew());
    end

    @(negedge clk);
    @(posedge clk);
    if (sbQueue.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sbQueue.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
